mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer sharing one single-port unified memory between the instruction-fetch path (driven from `pc`) and the load/store data path (driven from the ALU address and `rs2` data). It is the step from separate `instruction_mem`/`data_mem` to one memory. It grants one transaction at a time, with round-robin priority, and drives the memory port. It counts a fixed memory read latency and returns a response pulse to the owning requester.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both requesters and the memory.
- `DATA_W`, 32, data width; fixed at 32 so that `d_be` is 4 bits.
- `MEM_LAT`, 1, memory read latency in cycles; legal range 1..4.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `if_req`  in  1  fetch request; held high until granted.
- `if_addr`  in  ADDR_W  fetch byte address; sampled in the grant cycle.
- `if_gnt`  out  1  fetch granted this cycle.
- `if_rvalid`  out  1  fetch response valid; one-cycle pulse.
- `if_rdata`  out  DATA_W  instruction word; zero when `if_rvalid`=0.
- `d_req`  in  1  data request; held high until granted.
- `d_addr`  in  ADDR_W  data byte address.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  4  byte enables for a store.
- `d_wdata`  in  DATA_W  store data, already lane-aligned.
- `d_gnt`  out  1  data granted this cycle.
- `d_rvalid`  out  1  data response / store acknowledge; one-cycle pulse.
- `d_rdata`  out  DATA_W  load word; zero for stores and when `d_rvalid`=0.
- `mem_en`, `mem_we`  out  1  memory access strobe and write strobe.
- `mem_be`  out  4  memory byte enables.
- `mem_addr`  out  ADDR_W  word-aligned address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  read data, valid MEM_LAT cycles after the `mem_en` cycle.

## Operation
- States:
  - IDLE: no transaction is outstanding.
  - BUSY_IF: a fetch is outstanding.
  - BUSY_D: a data transaction is outstanding.
- Only one transaction is outstanding at a time.
- An open cycle is any cycle in IDLE, or the response cycle of a BUSY state.
- Arbitration happens in open cycles only.
  - Only one request high: that requester is granted.
  - Both requests high: the requester not granted last is granted, using the `last_d` flag.
  - `last_d` resets to 1, so fetch wins the first contended cycle after reset.
- Grant cycle:
  - `*_gnt`=1 and `mem_en`=1, combinationally.
  - `mem_addr`={addr[ADDR_W-1:2],2'b00}.
  - For a data grant: `mem_we`=`d_we`, `mem_be`=`d_we`?`d_be`:4'hF, `mem_wdata`=`d_wdata`.
  - For a fetch grant: `mem_we`=0, `mem_be`=4'hF.
  - Owner and `d_we` are registered. The FSM enters BUSY_<owner>, and the latency counter loads MEM_LAT-1.
- BUSY_x:
  - The counter decrements each cycle.
  - At counter 0, the response cycle: `x_rvalid`=1 and `x_rdata`=`mem_rdata` (for a load or fetch).
  - The FSM then goes to the next BUSY state if a new grant occurs in the same cycle, otherwise to IDLE.
- Stores also produce `d_rvalid` after MEM_LAT cycles, with `d_rdata`=0.
- When nothing is granted, all `mem_*` outputs are 0.

## Timing
- A grant at cycle T gives a response at T+MEM_LAT.
- Sustained throughput is one transaction per MEM_LAT cycles. With MEM_LAT=1, grants are back-to-back every cycle.
- A request dropped before grant is legal and is simply not served. Address and data may change until the grant cycle.
- While `rst`=0, all outputs are 0, the state is IDLE, the counter is 0 and `last_d`=1.
- Asserting reset mid-transaction discards the outstanding transaction. No `rvalid` is issued for it after release.
- The first grant is possible in the first rising edge cycle after reset deasserts.
- Simultaneous `rvalid` and `gnt` to the same or the other requester in one cycle is legal and required.
- An address above word alignment is never faulted; the low 2 bits are ignored.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, BUSY_IF, BUSY_D);
  - the owner encoding (OWN_IF=0, OWN_D=1);
  - localparams for the full byte-enable value (4'hF) and the MEM_LAT legal range.
- One sub-module, `rr_pick2`: a two-way round-robin picker with inputs `req[1:0]` and `last` and a one-hot grant output.
- The counter and FSM stay in `mem_port_arbiter`.

## Test plan
- Reset: hold `rst`=0 with both requests high. Expect all outputs 0. After release, expect fetch granted in the first cycle and `if_rvalid` exactly MEM_LAT cycles later.
- Contention, MEM_LAT=1, both requests held high for 6 cycles:
  - grants alternate IF,D,IF,D,IF,D;
  - `mem_addr` matches the granted address with bits[1:0]=0.
- Load, MEM_LAT=3: `d_addr`=0x103 and memory returns 0xDEADBEEF. Expect `mem_be`=4'hF and `mem_addr`=0x100, with `d_rvalid` and `d_rdata`=0xDEADBEEF at T+3.
- Store: `d_we`=1, `d_be`=4'b0011, `d_wdata`=0x0000BEEF. Expect `mem_we`=1 and `mem_be`=4'b0011 in the grant cycle, then `d_rvalid`=1 with `d_rdata`=0 at T+MEM_LAT.
- Reset mid-operation, MEM_LAT=4: reset asserted at T+2. Expect no `rvalid` pulse afterwards and a fresh fetch-first arbitration.
- Back-to-back, MEM_LAT=2, fetch request held: grants at T, T+2 and T+4, with each `if_rvalid` coinciding with the next `if_gnt`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_t : sequencer states (IDLE, BUSY_IF, BUSY_D)
//   owner_t     : requester encoding, also the bit index into grant vectors
//   BE_FULL     : byte-enable value for full-word reads
//   MEM_LAT_*   : legal memory read latency range
//   CNT_W       : latency counter width, enough to hold MEM_LAT_MAX-1
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [3:0] BE_FULL = 4'hF;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = 2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
//   req  : request vector, bit OWN_IF = fetch, bit OWN_D = data
//   last : 1 when the data requester was granted most recently
//   gnt  : one-hot grant (all zero when nothing is requested)
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt         = 2'b00;
        gnt[OWN_IF] = req[OWN_IF] & (~req[OWN_D] | last);
        gnt[OWN_D]  = req[OWN_D] & (~req[OWN_IF] | ~last);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction is outstanding at a time; the read latency is counted with
// a down-counter and a one-cycle response pulse goes back to the owner.
//   clk, rst              : clock, asynchronous active-low reset
//   if_req/if_addr        : fetch request and byte address
//   if_gnt/if_rvalid/if_rdata : fetch grant, response pulse, instruction word
//   d_req/d_addr/d_we/d_be/d_wdata : data request, address, store controls
//   d_gnt/d_rvalid/d_rdata : data grant, response/store ack, load word
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata : memory command port
//   mem_rdata             : memory read data, MEM_LAT cycles after mem_en
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | nothing outstanding, every cycle is open
// BUSY_IF | fetch outstanding, response when counter is 0
// BUSY_D  | data access outstanding, response at counter 0
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT out of range 1..4");
    end

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_d_q, last_d_d;
    logic             we_q, we_d;

    logic             open_cyc;
    logic             resp_cyc;
    logic [1:0]       req_v;
    logic [1:0]       pick;

    // Address bits below word alignment are intentionally ignored.
    logic             addr_lsb_unused;
    assign addr_lsb_unused = ^{if_addr[1:0], d_addr[1:0]};

    assign resp_cyc = (state_q != IDLE) && (cnt_q == '0);
    assign open_cyc = (state_q == IDLE) || resp_cyc;

    // Requests are masked by rst so that grants stay low while in reset.
    assign req_v = {d_req, if_req} & {2{open_cyc & rst}};

    rr_pick2 u_pick (
        .req  (req_v),
        .last (last_d_q),
        .gnt  (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b1;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            we_q     <= we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d_d  = last_d_q;
        we_d      = we_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (state_q != IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (resp_cyc) begin
            state_d = IDLE;
        end

        // A grant in the response cycle overrides the return to IDLE.
        if (pick[OWN_IF]) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_be   = BE_FULL;
            mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
            state_d  = BUSY_IF;
            cnt_d    = LAT_LOAD;
            last_d_d = 1'b0;
        end else if (pick[OWN_D]) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_we ? d_be : BE_FULL;
            mem_addr  = {d_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = d_wdata;
            state_d   = BUSY_D;
            cnt_d     = LAT_LOAD;
            last_d_d  = 1'b1;
            we_d      = d_we;
        end
    end

    assign if_rvalid = resp_cyc && (state_q == BUSY_IF);
    assign d_rvalid  = resp_cyc && (state_q == BUSY_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Four instances share all inputs and
// differ only in MEM_LAT (instance g has MEM_LAT = g+1); each scenario checks
// the instance whose latency it targets.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        if_gnt    [4];
    logic        if_rvalid [4];
    logic [31:0] if_rdata  [4];
    logic        d_gnt     [4];
    logic        d_rvalid  [4];
    logic [31:0] d_rdata   [4];
    logic        mem_en    [4];
    logic        mem_we    [4];
    logic [3:0]  mem_be    [4];
    logic [31:0] mem_addr  [4];
    logic [31:0] mem_wdata [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .MEM_LAT (g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req),
            .d_addr    (d_addr),
            .d_we      (d_we),
            .d_be      (d_be),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_be    (mem_be[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata)
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; checks run 1 time unit later.
    task automatic rst_hold();
        @(negedge clk);
        rst    = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr;
        logic        exp_if;

        // ---- reset with both requests high, then contention at MEM_LAT=1
        if_req  = 1'b1;
        d_req   = 1'b1;
        if_addr = 32'h0000_1001;
        d_addr  = 32'h0000_2006;
        @(negedge clk);
        #1;
        check_val("rst_if_gnt", 32'(if_gnt[0]), 32'd0);
        check_val("rst_d_gnt", 32'(d_gnt[0]), 32'd0);
        check_val("rst_mem_en", 32'(mem_en[0]), 32'd0);
        check_val("rst_mem_be", 32'(mem_be[0]), 32'd0);
        check_val("rst_mem_addr", mem_addr[0], 32'd0);
        check_val("rst_if_rvalid", 32'(if_rvalid[0]), 32'd0);
        check_val("rst_d_rvalid_l4", 32'(d_rvalid[3]), 32'd0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst       = 1'b1;
            mem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            exp_if   = (i % 2 == 0);
            exp_addr = exp_if ? 32'h0000_1000 : 32'h0000_2004;
            check_val($sformatf("cont_if_gnt%0d", i), 32'(if_gnt[0]), 32'(exp_if));
            check_val($sformatf("cont_d_gnt%0d", i), 32'(d_gnt[0]), 32'(!exp_if));
            check_val($sformatf("cont_addr%0d", i), mem_addr[0], exp_addr);
            check_val($sformatf("cont_if_rv%0d", i), 32'(if_rvalid[0]), 32'(i % 2 == 1));
            check_val($sformatf("cont_d_rv%0d", i), 32'(d_rvalid[0]), 32'(i > 0 && i % 2 == 0));
            check_val($sformatf("cont_if_rd%0d", i), if_rdata[0],
                      (i % 2 == 1) ? 32'hA000_0000 + 32'(i) : 32'd0);
        end
        @(negedge clk);
        if_req = 1'b0;
        d_req  = 1'b0;
        #1;
        check_val("cont_tail_d_rv", 32'(d_rvalid[0]), 32'd1);
        check_val("cont_tail_mem_en", 32'(mem_en[0]), 32'd0);
        @(negedge clk);
        #1;
        check_val("cont_idle_d_rv", 32'(d_rvalid[0]), 32'd0);

        // ---- load at MEM_LAT=3 (instance 2)
        rst_hold();
        @(negedge clk);
        rst    = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_be   = 4'h0;
        d_addr = 32'h0000_0103;
        #1;
        check_val("ld_gnt", 32'(d_gnt[2]), 32'd1);
        check_val("ld_mem_be", 32'(mem_be[2]), 32'hF);
        check_val("ld_mem_addr", mem_addr[2], 32'h0000_0100);
        check_val("ld_mem_we", 32'(mem_we[2]), 32'd0);
        @(negedge clk);
        d_req     = 1'b0;
        mem_rdata = 32'h1234_5678;
        #1;
        check_val("ld_t1_rv", 32'(d_rvalid[2]), 32'd0);
        check_val("ld_t1_rdata", d_rdata[2], 32'd0);
        @(negedge clk);
        #1;
        check_val("ld_t2_rv", 32'(d_rvalid[2]), 32'd0);
        @(negedge clk);
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check_val("ld_t3_rv", 32'(d_rvalid[2]), 32'd1);
        check_val("ld_t3_rdata", d_rdata[2], 32'hDEAD_BEEF);
        check_val("ld_t3_if_rv", 32'(if_rvalid[2]), 32'd0);
        @(negedge clk);
        #1;
        check_val("ld_t4_rv", 32'(d_rvalid[2]), 32'd0);

        // ---- store at MEM_LAT=2 (instance 1)
        rst_hold();
        @(negedge clk);
        rst     = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_wdata = 32'h0000_BEEF;
        d_addr  = 32'h0000_0022;
        #1;
        check_val("st_gnt", 32'(d_gnt[1]), 32'd1);
        check_val("st_mem_we", 32'(mem_we[1]), 32'd1);
        check_val("st_mem_be", 32'(mem_be[1]), 32'h3);
        check_val("st_wdata", mem_wdata[1], 32'h0000_BEEF);
        check_val("st_mem_addr", mem_addr[1], 32'h0000_0020);
        @(negedge clk);
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        check_val("st_t1_rv", 32'(d_rvalid[1]), 32'd0);
        check_val("st_t1_mem_en", 32'(mem_en[1]), 32'd0);
        @(negedge clk);
        #1;
        check_val("st_t2_rv", 32'(d_rvalid[1]), 32'd1);
        check_val("st_t2_rdata", d_rdata[1], 32'd0);

        // ---- reset mid-transaction at MEM_LAT=4 (instance 3)
        rst_hold();
        @(negedge clk);
        rst    = 1'b1;
        d_req  = 1'b1;
        d_addr = 32'h0000_0040;
        #1;
        check_val("mr_d_gnt", 32'(d_gnt[3]), 32'd1);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("mr_in_rst_rv", 32'(d_rvalid[3]), 32'd0);
        check_val("mr_in_rst_en", 32'(mem_en[3]), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        if_req  = 1'b1;
        d_req   = 1'b1;
        if_addr = 32'h0000_0080;
        #1;
        check_val("mr_if_first", 32'(if_gnt[3]), 32'd1);
        check_val("mr_d_not", 32'(d_gnt[3]), 32'd0);
        check_val("mr_addr", mem_addr[3], 32'h0000_0080);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if_req = 1'b0;
            d_req  = 1'b0;
            #1;
            check_val($sformatf("mr_d_rv%0d", k), 32'(d_rvalid[3]), 32'd0);
            check_val($sformatf("mr_if_rv%0d", k), 32'(if_rvalid[3]), 32'(k == 4));
        end

        // ---- back-to-back fetches at MEM_LAT=2 (instance 1)
        rst_hold();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst       = 1'b1;
            if_req    = 1'b1;
            if_addr   = 32'h0000_0201 + 32'(4 * i);
            mem_rdata = 32'hC0DE_0000 + 32'(i);
            #1;
            check_val($sformatf("b2b_gnt%0d", i), 32'(if_gnt[1]), 32'(i % 2 == 0));
            check_val($sformatf("b2b_rv%0d", i), 32'(if_rvalid[1]), 32'(i == 2 || i == 4));
            check_val($sformatf("b2b_rd%0d", i), if_rdata[1],
                      (i == 2 || i == 4) ? 32'hC0DE_0000 + 32'(i) : 32'd0);
            check_val($sformatf("b2b_addr%0d", i), mem_addr[1],
                      (i % 2 == 0) ? 32'h0000_0200 + 32'(4 * i) : 32'd0);
        end
        @(negedge clk);
        if_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
